// File: rtl/rgb_fade_seq_if.sv
// Command channel into rgb_fade_seq: target colour, step rate and abort.
// Latency: none, wires only. Backpressure: cmd_ready low holds the source.
// The master keeps its fields stable while cmd_valid is high and cmd_ready is low.
interface rgb_fade_seq_if #(
    parameter int BRIGHT_W = 15,
    parameter int RATE_W   = 16
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [BRIGHT_W-1:0] cmd_red;
    logic [BRIGHT_W-1:0] cmd_green;
    logic [BRIGHT_W-1:0] cmd_blue;
    logic [RATE_W-1:0]   cmd_rate;
    logic                cmd_abort;

    modport master (
        output cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_rate, cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_rate, cmd_abort,
        output cmd_ready
    );
endinterface

// File: rtl/rgb_fade_seq.sv
// Linear RGB fade sequencer feeding rgb_led_ctrl brightness inputs.
// Latency: step k lands rate_eff*k cycles after accept; done coincides with final values.
// Backpressure: cmd_ready is low for the whole ramp; abort returns to idle next edge.
module rgb_fade_seq #(
    parameter int BRIGHT_W = 15,
    parameter int RATE_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    rgb_fade_seq_if.slave       cmd,
    output logic [BRIGHT_W-1:0] red,
    output logic [BRIGHT_W-1:0] green,
    output logic [BRIGHT_W-1:0] blue,
    output logic                busy,
    output logic                done
);
    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [BRIGHT_W-1:0] ONE_B  = BRIGHT_W'(1);
    localparam logic [RATE_W-1:0]   ONE_R  = RATE_W'(1);
    localparam logic [RATE_W-1:0]   ZERO_R = '0;

    state_t              state_q, state_d;
    logic [BRIGHT_W-1:0] red_d, green_d, blue_d;
    logic [BRIGHT_W-1:0] tgt_r_q, tgt_g_q, tgt_b_q;
    logic [BRIGHT_W-1:0] tgt_r_d, tgt_g_d, tgt_b_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   cnt_q, cnt_d;
    logic                done_d;
    logic [BRIGHT_W-1:0] nxt_r, nxt_g, nxt_b;
    logic                step, last_step, cmd_is_null;

    // The target bounds every move, so a channel can never wrap past 0 or full scale.
    function automatic logic [BRIGHT_W-1:0] step_toward(input logic [BRIGHT_W-1:0] cur,
                                                        input logic [BRIGHT_W-1:0] tgt);
        logic [BRIGHT_W-1:0] res;
        res = cur;
        if (cur < tgt)
            res = cur + ONE_B;
        else if (cur > tgt)
            res = cur - ONE_B;
        return res;
    endfunction

    assign nxt_r       = step_toward(red,   tgt_r_q);
    assign nxt_g       = step_toward(green, tgt_g_q);
    assign nxt_b       = step_toward(blue,  tgt_b_q);
    assign step        = (cnt_q == rate_q - ONE_R);
    assign last_step   = (nxt_r == tgt_r_q) && (nxt_g == tgt_g_q) && (nxt_b == tgt_b_q);
    assign cmd_is_null = (cmd.cmd_red == red) && (cmd.cmd_green == green) && (cmd.cmd_blue == blue);

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q == RAMP);

    always_comb begin
        state_d = state_q;
        red_d   = red;
        green_d = green;
        blue_d  = blue;
        tgt_r_d = tgt_r_q;
        tgt_g_d = tgt_g_q;
        tgt_b_d = tgt_b_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    tgt_r_d = cmd.cmd_red;
                    tgt_g_d = cmd.cmd_green;
                    tgt_b_d = cmd.cmd_blue;
                    rate_d  = (cmd.cmd_rate == ZERO_R) ? ONE_R : cmd.cmd_rate;
                    cnt_d   = ZERO_R;
                    if (cmd_is_null)
                        done_d = 1'b1;
                    else
                        state_d = RAMP;
                end
            end
            RAMP: begin
                // A final step beats a coincident abort; any other abort freezes outputs.
                if (step && last_step) begin
                    red_d   = nxt_r;
                    green_d = nxt_g;
                    blue_d  = nxt_b;
                    cnt_d   = ZERO_R;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cmd.cmd_abort) begin
                    cnt_d   = ZERO_R;
                    state_d = IDLE;
                end else if (step) begin
                    red_d   = nxt_r;
                    green_d = nxt_g;
                    blue_d  = nxt_b;
                    cnt_d   = ZERO_R;
                end else begin
                    cnt_d = cnt_q + ONE_R;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            tgt_r_q <= '0;
            tgt_g_q <= '0;
            tgt_b_q <= '0;
            rate_q  <= ONE_R;
            cnt_q   <= ZERO_R;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            red     <= red_d;
            green   <= green_d;
            blue    <= blue_d;
            tgt_r_q <= tgt_r_d;
            tgt_g_q <= tgt_g_d;
            tgt_b_q <= tgt_b_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            done    <= done_d;
        end
    end
endmodule

// File: tb/tb_rgb_fade_seq.sv
// Randomised bench for rgb_fade_seq: per-cycle trajectory checks from a closed-form
// model plus a done-pulse scoreboard popped by an independent monitor.
module tb_rgb_fade_seq;
    localparam int BW = 15;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] red, green, blue;
    logic          busy, done;

    rgb_fade_seq_if #(.BRIGHT_W(BW), .RATE_W(RW)) cmd_if ();

    rgb_fade_seq #(.BRIGHT_W(BW), .RATE_W(RW)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cmd_if),
        .red   (red),
        .green (green),
        .blue  (blue),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int r;
        int g;
        int b;
        int at;
    } exp_t;
    exp_t sb[$];

    int cur_r = 0, cur_g = 0, cur_b = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rgb(input string name, input int er, input int eg, input int eb);
        tests++;
        if (red !== BW'(er) || green !== BW'(eg) || blue !== BW'(eb)) begin
            fails++;
            $display("FAIL %s: got rgb=(%0d,%0d,%0d), expected (%0d,%0d,%0d) (cycle %0d)",
                     name, red, green, blue, er, eg, eb, cyc);
        end
    endtask

    // Channel value t cycles after accept: start moved floor(t/rate) LSBs toward target.
    function automatic int traj(input int s, input int tg, input int reff, input int t);
        int n;
        n = t / reff;
        if (tg >= s)
            return s + (((tg - s) < n) ? (tg - s) : n);
        else
            return s - (((s - tg) < n) ? (s - tg) : n);
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding completion.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.at);
                check_rgb("done_colour", e.r, e.g, e.b);
            end
        end
    end

    // mode: 0 plain, 1 abort at edge E0+at (at<=0 picks one), 2 async reset after cycle at.
    // hold: after accept keep cmd_valid high with the next command (hr,hg,hb,hrate).
    task automatic run_cmd(input int r, input int g, input int b, input int rate,
                           input int mode_in, input int at_in, input bit hold,
                           input int hr, input int hg, input int hb, input int hrate);
        int reff, dur, e0, mode, at, m;
        bit got;
        mode = mode_in;
        at   = at_in;
        cmd_if.cmd_red   = BW'(r);
        cmd_if.cmd_green = BW'(g);
        cmd_if.cmd_blue  = BW'(b);
        cmd_if.cmd_rate  = RW'(rate);
        cmd_if.cmd_valid = 1'b1;
        reff = (rate == 0) ? 1 : rate;
        m = absd(r, cur_r);
        if (absd(g, cur_g) > m) m = absd(g, cur_g);
        if (absd(b, cur_b) > m) m = absd(b, cur_b);
        dur = m * reff;
        if (dur == 0) mode = 0;
        if (mode == 1 && at <= 0) at = $urandom_range(1, dur);
        if (mode == 2 && (at <= 0 || at >= dur)) mode = 0;

        got = 1'b0;
        for (int w = 0; w < 1000 && !got; w++) begin
            if (cmd_if.cmd_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        e0 = cyc + 1;
        if (mode == 0 || (mode == 1 && at >= dur))
            sb.push_back('{r: r, g: g, b: b, at: e0 + dur});

        for (int t = 0; t <= dur; t++) begin
            @(negedge clk);
            if (t == 0) begin
                cmd_if.cmd_valid = hold;
                if (hold) begin
                    cmd_if.cmd_red   = BW'(hr);
                    cmd_if.cmd_green = BW'(hg);
                    cmd_if.cmd_blue  = BW'(hb);
                    cmd_if.cmd_rate  = RW'(hrate);
                end
            end
            if (mode == 1 && t == at) begin
                cmd_if.cmd_abort = 1'b0;
                if (at < dur) begin
                    cur_r = traj(cur_r, r, reff, at - 1);
                    cur_g = traj(cur_g, g, reff, at - 1);
                    cur_b = traj(cur_b, b, reff, at - 1);
                    check_rgb("abort_frozen", cur_r, cur_g, cur_b);
                    check("abort_busy", busy, 0);
                    check("abort_ready", cmd_if.cmd_ready, 1);
                    return;
                end
            end
            check_rgb("ramp_colour", traj(cur_r, r, reff, t), traj(cur_g, g, reff, t),
                      traj(cur_b, b, reff, t));
            check("ramp_busy", busy, (t < dur) ? 1 : 0);
            check("ramp_ready", cmd_if.cmd_ready, (t < dur) ? 0 : 1);
            if (mode == 1 && t == at - 1) cmd_if.cmd_abort = 1'b1;
            if (mode == 2 && t == at) begin
                #2 rst = 1'b1;
                #1;
                check_rgb("async_rst_colour", 0, 0, 0);
                check("async_rst_busy", busy, 0);
                check("async_rst_done", done, 0);
                check("async_rst_ready", cmd_if.cmd_ready, 1);
                cmd_if.cmd_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_rgb("post_rst_colour", 0, 0, 0);
                sb.delete();
                cur_r = 0;
                cur_g = 0;
                cur_b = 0;
                return;
            end
        end
        cur_r = r;
        cur_g = g;
        cur_b = b;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int nr, ng, nb, mode;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_abort = 1'b0;
        cmd_if.cmd_red   = '0;
        cmd_if.cmd_green = '0;
        cmd_if.cmd_blue  = '0;
        cmd_if.cmd_rate  = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_rgb("reset_colour", 0, 0, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ready", cmd_if.cmd_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Up-ramp, down-ramp at rate 0, null command, abort with a held follow-up command.
        run_cmd(3, 0, 1, 2, 0, 0, 1'b0, 0, 0, 0, 0);
        run_cmd(3, 3, 0, 1, 0, 0, 1'b0, 0, 0, 0, 0);
        run_cmd(0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        run_cmd(0, 0, 0, 5, 0, 0, 1'b0, 0, 0, 0, 0);
        run_cmd(10, 0, 0, 4, 1, 9, 1'b1, 5, 5, 5, 1);
        run_cmd(5, 5, 5, 1, 0, 0, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                nr = cur_r;
                ng = cur_g;
                nb = cur_b;
            end else begin
                nr = $urandom_range(0, 40);
                ng = $urandom_range(0, 40);
                nb = $urandom_range(0, 40);
            end
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_cmd(nr, ng, nb, $urandom_range(0, 4), mode, 0, 1'b0, 0, 0, 0, 0);
        end

        // Full-scale ramp, then a reset in the middle of a ramp.
        run_cmd(0, 0, 0, 1, 0, 0, 1'b0, 0, 0, 0, 0);
        run_cmd(32767, 32767, 32767, 1, 0, 0, 1'b0, 0, 0, 0, 0);
        run_cmd(100, 200, 300, 2, 2, 50, 1'b0, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
